// File: rtl/fft4_frame_if.sv
// Stream and core-side bundle for the 4-point FFT/IFFT frame sequencer.
//  slave  : controller view (accepts the input stream, drives the core and the output stream)
//  master : environment view (drives the input stream, returns the core result, sinks the output)
//  Input stream : in_valid, in_ready, in_real, in_imag, in_inv
//  Core side    : core_re_in, core_im_in, core_inv, core_re_out, core_im_out ({x3,x2,x1,x0})
//  Output stream: out_valid, out_ready, out_real, out_imag, out_idx, out_last, out_inv, busy
interface fft4_frame_if #(
    parameter int unsigned DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_real;
    logic [DATA_W-1:0]     in_imag;
    logic                  in_inv;

    logic [4*DATA_W-1:0]   core_re_in;
    logic [4*DATA_W-1:0]   core_im_in;
    logic                  core_inv;
    logic [4*DATA_W-1:0]   core_re_out;
    logic [4*DATA_W-1:0]   core_im_out;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_real;
    logic [DATA_W-1:0]     out_imag;
    logic [1:0]            out_idx;
    logic                  out_last;
    logic                  out_inv;
    logic                  busy;

    modport slave (
        input  in_valid, in_real, in_imag, in_inv,
        input  core_re_out, core_im_out,
        input  out_ready,
        output in_ready,
        output core_re_in, core_im_in, core_inv,
        output out_valid, out_real, out_imag, out_idx, out_last, out_inv, busy
    );

    modport master (
        output in_valid, in_real, in_imag, in_inv,
        output core_re_out, core_im_out,
        output out_ready,
        input  in_ready,
        input  core_re_in, core_im_in, core_inv,
        input  out_valid, out_real, out_imag, out_idx, out_last, out_inv, busy
    );
endinterface

// File: rtl/fft4_frame_ctrl.sv
// Frame sequencer for the shared 4-point FFT/IFFT core pair.
// Collects 4 serial complex samples, presents them in parallel to the core, registers
// the core result one cycle later and replays it as a serial stream with bin index.
//  clk    : rising-edge clock
//  rst_n  : asynchronous active-low reset
//  bus    : fft4_frame_if.slave (input stream, core side, output stream, busy)
// Optional build macro OVERLAP_EN: the next frame may be loaded while the previous
// result drains (input and result buffers are already independent).
module fft4_frame_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fft4_frame_if.slave   bus
);
    localparam int unsigned FRAME_N = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef logic [FRAME_N-1:0][DATA_W-1:0] frame_t;

    logic [1:0]        state_q,     state_d;
    logic [IDX_W-1:0]  in_cnt_q,    in_cnt_d;
    frame_t            smp_re_q,    smp_re_d;
    frame_t            smp_im_q,    smp_im_d;
    logic              mode_q,      mode_d;
    frame_t            res_re_q,    res_re_d;
    frame_t            res_im_q,    res_im_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic              out_inv_q,   out_inv_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;
    logic              out_last_q,  out_last_d;
    logic [DATA_W-1:0] out_real_q,  out_real_d;
    logic [DATA_W-1:0] out_imag_q,  out_imag_d;
`ifdef OVERLAP_EN
    logic              pend_q,      pend_d;
`endif

    logic in_fire;
    logic out_fire;
    logic frame_done;
    logic drain_done;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            in_cnt_q    <= '0;
            smp_re_q    <= '0;
            smp_im_q    <= '0;
            mode_q      <= 1'b0;
            res_re_q    <= '0;
            res_im_q    <= '0;
            idx_q       <= '0;
            out_inv_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_last_q  <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
`ifdef OVERLAP_EN
            pend_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            smp_re_q    <= smp_re_d;
            smp_im_q    <= smp_im_d;
            mode_q      <= mode_d;
            res_re_q    <= res_re_d;
            res_im_q    <= res_im_d;
            idx_q       <= idx_d;
            out_inv_q   <= out_inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_last_q  <= out_last_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
`ifdef OVERLAP_EN
            pend_q      <= pend_d;
`endif
        end
    end

    // Next-state, buffer updates and next values of the registered outputs
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        smp_re_d   = smp_re_q;
        smp_im_d   = smp_im_q;
        mode_d     = mode_q;
        res_re_d   = res_re_q;
        res_im_d   = res_im_q;
        idx_d      = idx_q;
        out_inv_d  = out_inv_q;
`ifdef OVERLAP_EN
        pend_d     = pend_q;
`endif

        in_fire    = bus.in_valid && in_ready_q;
        out_fire   = out_valid_q && bus.out_ready;
        frame_done = in_fire && (in_cnt_q == IDX_W'(FRAME_N - 1));
        drain_done = out_fire && (idx_q == IDX_W'(FRAME_N - 1));

        // Input side: slot write, mode latched with the first sample only
        if (in_fire) begin
            smp_re_d[in_cnt_q] = bus.in_real;
            smp_im_d[in_cnt_q] = bus.in_imag;
            if (in_cnt_q == '0) begin
                mode_d = bus.in_inv;
            end
            in_cnt_d = in_cnt_q + IDX_W'(1);
        end

        case (state_q)
            S_LOAD: begin
                if (frame_done) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_re_d  = bus.core_re_out;
                res_im_d  = bus.core_im_out;
                out_inv_d = mode_q;
                idx_d     = '0;
                state_d   = S_DRAIN;
`ifdef OVERLAP_EN
                pend_d    = 1'b0;
`endif
            end
            S_DRAIN: begin
                if (out_fire) begin
                    idx_d = idx_q + IDX_W'(1);
                end
`ifdef OVERLAP_EN
                // A frame finished here either starts CALC right away or waits as pending
                if (drain_done) begin
                    state_d = (pend_q || frame_done) ? S_CALC : S_LOAD;
                    pend_d  = 1'b0;
                end else if (frame_done) begin
                    pend_d  = 1'b1;
                end
`else
                if (drain_done) begin
                    state_d = S_LOAD;
                end
`endif
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        // Outputs registered from the next state so they line up with it
        in_ready_d  = (state_d == S_LOAD);
`ifdef OVERLAP_EN
        if ((state_d == S_DRAIN) && !pend_d) begin
            in_ready_d = 1'b1;
        end
`endif
        out_valid_d = (state_d == S_DRAIN);
        busy_d      = (state_d != S_LOAD);
        out_last_d  = out_valid_d && (idx_d == IDX_W'(FRAME_N - 1));
        out_real_d  = res_re_d[idx_d];
        out_imag_d  = res_im_d[idx_d];
    end

    assign bus.core_re_in = smp_re_q;
    assign bus.core_im_in = smp_im_q;
    assign bus.core_inv   = mode_q;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_real   = out_real_q;
    assign bus.out_imag   = out_imag_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_inv    = out_inv_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// Bench for fft4_frame_ctrl: a butterfly-form core stub closes the core loop, and a
// frame-level DFT model predicts handshakes and the output stream.
module tb_fft4_frame_ctrl;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    fft4_frame_if #(.DATA_W(DW)) bus();

    fft4_frame_ctrl #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Core stub: radix-2 butterflies, IFFT uses conjugate twiddles and /4 toward zero
    function automatic void core_fn(input logic [4*DW-1:0] re, input logic [4*DW-1:0] im,
                                    input logic inv,
                                    output logic [4*DW-1:0] ore, output logic [4*DW-1:0] oim);
        int xr [4];
        int xi [4];
        int yr [4];
        int yi [4];
        int ar, ai, br, bi, cr, ci, dr, di;
        for (int n = 0; n < 4; n++) begin
            xr[n] = int'($signed(re[n*DW +: DW]));
            xi[n] = int'($signed(im[n*DW +: DW]));
        end
        ar = xr[0] + xr[2]; ai = xi[0] + xi[2];
        br = xr[0] - xr[2]; bi = xi[0] - xi[2];
        cr = xr[1] + xr[3]; ci = xi[1] + xi[3];
        dr = xr[1] - xr[3]; di = xi[1] - xi[3];
        yr[0] = ar + cr; yi[0] = ai + ci;
        yr[2] = ar - cr; yi[2] = ai - ci;
        if (!inv) begin
            yr[1] = br + di; yi[1] = bi - dr;
            yr[3] = br - di; yi[3] = bi + dr;
        end else begin
            yr[1] = br - di; yi[1] = bi + dr;
            yr[3] = br + di; yi[3] = bi - dr;
            for (int k = 0; k < 4; k++) begin
                yr[k] = yr[k] / 4;
                yi[k] = yi[k] / 4;
            end
        end
        ore = '0;
        oim = '0;
        for (int k = 0; k < 4; k++) begin
            ore[k*DW +: DW] = DW'(yr[k]);
            oim[k*DW +: DW] = DW'(yi[k]);
        end
    endfunction

    logic [4*DW-1:0] cre, cim;
    always_comb begin
        core_fn(bus.core_re_in, bus.core_im_in, bus.core_inv, cre, cim);
    end
    assign bus.core_re_out = cre;
    assign bus.core_im_out = cim;

    // Reference: direct DFT sum with twiddle (-j)^(k*n) (or (+j)^(k*n) for IFFT, then /4)
    function automatic void dft(input int xr [4], input int xi [4], input logic inv,
                                output int yr [4], output int yi [4]);
        int m, sr, si;
        for (int k = 0; k < 4; k++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < 4; n++) begin
                m = (k * n) % 4;
                if (inv) m = (4 - m) % 4;
                case (m)
                    0: begin sr += xr[n]; si += xi[n]; end
                    1: begin sr += xi[n]; si -= xr[n]; end
                    2: begin sr -= xr[n]; si -= xi[n]; end
                    default: begin sr -= xi[n]; si += xr[n]; end
                endcase
            end
            if (inv) begin
                sr = sr / 4;
                si = si / 4;
            end
            yr[k] = sr;
            yi[k] = si;
        end
    endfunction

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [1:0]    idx;
        logic          last;
        logic          inv;
    } exp_t;

    exp_t exp_q [$];
    int   nfr   = 0;     // complete frames accepted and not yet fully drained
    int   pcnt  = 0;     // samples of the frame being loaded
    int   n_out = 0;     // outputs already taken from the head frame
    logic calc  = 1'b0;  // head frame is in its one-cycle compute slot
    int   part_r [4];
    int   part_i [4];
    logic part_inv = 1'b0;

    // Compare process plus model update, once per cycle away from the active edge
    always @(negedge clk) begin : model
        logic exp_ready, exp_valid, in_fire, out_fire, new_calc;
        int   yr [4];
        int   yi [4];
        if (!rst_n) begin
            chk("reset_outputs",
                32'({bus.in_ready, bus.out_valid, bus.out_last, bus.out_inv, bus.busy}),
                32'(5'b10000));
            exp_q.delete();
            nfr   = 0;
            pcnt  = 0;
            n_out = 0;
            calc  = 1'b0;
        end else begin
`ifdef OVERLAP_EN
            exp_ready = !calc && (nfr < 2);
`else
            exp_ready = (nfr == 0);
`endif
            exp_valid = (nfr > 0) && !calc;
            chk("in_ready",  32'(bus.in_ready),  32'(exp_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            chk("busy",      32'(bus.busy),      32'(nfr > 0));
            if (exp_valid && bus.out_valid) begin
                chk("out_sample",
                    32'({bus.out_real, bus.out_imag, bus.out_idx, bus.out_last, bus.out_inv}),
                    32'(exp_q[0]));
            end

            in_fire  = bus.in_valid && exp_ready;
            out_fire = exp_valid && bus.out_ready;
            new_calc = 1'b0;
            if (out_fire) begin
                void'(exp_q.pop_front());
                n_out++;
                if (n_out == 4) begin
                    n_out = 0;
                    nfr--;
                    if (nfr > 0) new_calc = 1'b1;
                end
            end
            if (in_fire) begin
                part_r[pcnt] = int'($signed(bus.in_real));
                part_i[pcnt] = int'($signed(bus.in_imag));
                if (pcnt == 0) part_inv = bus.in_inv;
                pcnt++;
                if (pcnt == 4) begin
                    pcnt = 0;
                    dft(part_r, part_i, part_inv, yr, yi);
                    for (int k = 0; k < 4; k++) begin
                        exp_q.push_back('{re: DW'(yr[k]), im: DW'(yi[k]), idx: 2'(k),
                                          last: (k == 3), inv: part_inv});
                    end
                    nfr++;
                    if (nfr == 1) new_calc = 1'b1;
                end
            end
            calc = new_calc;
        end
    end

    int         rdy_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0,1
    logic [3:0] pat = 4'b1001;
    int         ph = 0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                2: begin bus.out_ready = pat[ph]; ph = (ph + 1) % 4; end
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic inv);
        int   cnt;
        logic fired;
        bus.in_valid = 1'b1;
        bus.in_real  = re;
        bus.in_imag  = im;
        bus.in_inv   = inv;
        cnt   = 0;
        fired = 1'b0;
        while (!fired && cnt < 200) begin
            @(negedge clk);
            fired = bus.in_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        if (!fired) chk("send_timeout", 32'(0), 32'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while (!(nfr == 0 && pcnt == 0) && cnt < 500) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 500) chk("drain_timeout", 32'(0), 32'(1));
    endtask

    task automatic pulse_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [4*DW-1:0] re, input logic [4*DW-1:0] im,
                              input logic [3:0] inv);
        for (int s = 0; s < 4; s++) begin
            send(re[s*DW +: DW], im[s*DW +: DW], inv[s]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int xr [4];
        int xi [4];
        int yr [4];
        int yi [4];
        bus.in_valid = 1'b0;
        bus.in_real  = '0;
        bus.in_imag  = '0;
        bus.in_inv   = 1'b0;

        // Pin the reference model with hand-computed transforms
        xr = '{1, 1, 1, 1}; xi = '{0, 0, 0, 0};
        dft(xr, xi, 1'b0, yr, yi);
        chk("pin_fft_dc_x0", 32'(yr[0]), 32'(4));
        chk("pin_fft_dc_x1", 32'(yr[1]), 32'(0));
        chk("pin_fft_dc_x3", 32'(yi[3]), 32'(0));
        xr = '{4, 0, 0, 0};
        dft(xr, xi, 1'b1, yr, yi);
        chk("pin_ifft_x2", 32'(yr[2]), 32'(1));
        xr = '{0, 1, 0, 0};
        dft(xr, xi, 1'b0, yr, yi);
        chk("pin_fft_x1_im", 32'(yi[1]), 32'(-1));
        chk("pin_fft_x3_im", 32'(yi[3]), 32'(1));
        chk("pin_fft_x2_re", 32'(yr[2]), 32'(-1));

        #1 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // DC frame through FFT, then unit impulse of 4 through IFFT
        rdy_mode = 0;
        send_frame({8'd1, 8'd1, 8'd1, 8'd1}, '0, 4'b0000);
        wait_drain();
        send_frame({8'd0, 8'd0, 8'd0, 8'd4}, '0, 4'b1111);
        wait_drain();

        // Stalled drain with a 1,0,0,1 ready pattern
        rdy_mode = 2;
        send_frame({8'd7, 8'hF3, 8'd100, 8'h80}, {8'd2, 8'd127, 8'hFE, 8'd9}, 4'b0000);
        wait_drain();

        // Mode taken from the first sample only
        rdy_mode = 0;
        send_frame({8'd8, 8'd12, 8'd16, 8'd20}, {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0001);
        send_frame({8'd8, 8'd12, 8'd16, 8'd20}, {8'd4, 8'd3, 8'd2, 8'd1}, 4'b1110);
        wait_drain();

        // Reset with a partial frame, then a clean frame
        send(8'd50, 8'd60, 1'b1);
        send(8'd70, 8'd80, 1'b1);
        pulse_reset();
        send_frame({8'd3, 8'd2, 8'd1, 8'd5}, {8'd0, 8'd1, 8'd0, 8'd1}, 4'b0000);
        wait_drain();

        // Back-to-back frames with everything ready
        rdy_mode = 0;
        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < 4; s++) begin
                send(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
            end
        end
        wait_drain();

        // Random data, modes, gaps and downstream stalls
        rdy_mode = 1;
        for (int f = 0; f < 30; f++) begin
            for (int s = 0; s < 4; s++) begin
                send(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        wait_drain();
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
